// File: rtl/sram_fb_arbiter.sv
// Single-port async SRAM arbiter: display reads win, draw writes are forced after a bounded read streak.
// Optional grant statistics are built when SRAM_ARB_STATS_EN is defined.
module sram_fb_arbiter #(
   parameter int AW           = 20,
   parameter int DW           = 16,
   parameter int ACC_CYCLES   = 2,
   parameter int MAX_RD_BURST = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_rd_req,
   input  logic [AW-1:0] i_rd_addr,
   output logic          o_rd_gnt,
   output logic          o_rd_valid,
   output logic [DW-1:0] o_rd_data,
   input  logic          i_wr_req,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic [1:0]    i_wr_be,
   output logic          o_wr_gnt,
   output logic          o_busy,
   output logic [AW-1:0] o_sram_addr,
   output logic [DW-1:0] o_sram_dq,
   output logic          o_sram_dq_oe,
   input  logic [DW-1:0] i_sram_dq,
   output logic          o_sram_ce_n,
   output logic          o_sram_oe_n,
   output logic          o_sram_we_n,
   output logic          o_sram_lb_n,
   output logic          o_sram_ub_n,
   output logic [31:0]   o_cnt_rd,
   output logic [31:0]   o_cnt_wr,
   output logic [15:0]   o_cnt_force
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_TURN = 2'd3;
   localparam logic [2:0] LAST   = 3'(ACC_CYCLES - 1);
   localparam logic [7:0] BURST  = 8'(MAX_RD_BURST);

   logic [1:0] state, nxt_state;
   logic [2:0] cyc, nxt_cyc;
   logic [7:0] rd_streak;
   logic [1:0] be_q, be_nxt;
   logic       last, arb, force_wr, rd_sel, wr_sel;

   assign last     = (cyc == LAST);
   assign arb      = (state == S_IDLE) || (((state == S_RD) || (state == S_WR)) && last);
   assign force_wr = i_wr_req && (rd_streak >= BURST);
   assign be_nxt   = wr_sel ? i_wr_be : be_q;

   always_comb begin
      nxt_state = state;
      nxt_cyc   = cyc;
      rd_sel    = 1'b0;
      wr_sel    = 1'b0;
      if (arb) begin
         nxt_cyc = 3'd0;
         if (i_rd_req && !force_wr) begin
            // Bus must float for a cycle before the SRAM drives it after our write
            if (state == S_WR) begin
               nxt_state = S_TURN;
            end else begin
               nxt_state = S_RD;
               rd_sel    = 1'b1;
            end
         end else if (i_wr_req) begin
            nxt_state = S_WR;
            wr_sel    = 1'b1;
         end else begin
            nxt_state = S_IDLE;
         end
      end else if (state == S_TURN) begin
         nxt_cyc = 3'd0;
         if (i_rd_req) begin
            nxt_state = S_RD;
            rd_sel    = 1'b1;
         end else if (i_wr_req) begin
            nxt_state = S_WR;
            wr_sel    = 1'b1;
         end else begin
            nxt_state = S_IDLE;
         end
      end else begin
         nxt_cyc = cyc + 3'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         cyc          <= 3'd0;
         rd_streak    <= 8'd0;
         be_q         <= 2'b00;
         o_rd_gnt     <= 1'b0;
         o_wr_gnt     <= 1'b0;
         o_rd_valid   <= 1'b0;
         o_rd_data    <= '0;
         o_busy       <= 1'b0;
         o_sram_addr  <= '0;
         o_sram_dq    <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
         o_sram_lb_n  <= 1'b1;
         o_sram_ub_n  <= 1'b1;
      end else begin
         state      <= nxt_state;
         cyc        <= nxt_cyc;
         o_rd_gnt   <= rd_sel;
         o_wr_gnt   <= wr_sel;
         o_busy     <= (nxt_state != S_IDLE);
         o_rd_valid <= (state == S_RD) && last;
         if ((state == S_RD) && last) o_rd_data <= i_sram_dq;
         if (rd_sel) o_sram_addr <= i_rd_addr;
         if (wr_sel) begin
            o_sram_addr <= i_wr_addr;
            o_sram_dq   <= i_wr_data;
            be_q        <= i_wr_be;
         end
         case (nxt_state)
            S_RD: begin
               o_sram_ce_n  <= 1'b0;
               o_sram_oe_n  <= 1'b0;
               o_sram_we_n  <= 1'b1;
               o_sram_lb_n  <= 1'b0;
               o_sram_ub_n  <= 1'b0;
               o_sram_dq_oe <= 1'b0;
            end
            S_WR: begin
               // Last write cycle releases we_n early to give data hold time
               o_sram_ce_n  <= 1'b0;
               o_sram_oe_n  <= 1'b1;
               o_sram_we_n  <= (ACC_CYCLES == 1) ? 1'b0 : (nxt_cyc == LAST);
               o_sram_lb_n  <= ~be_nxt[0];
               o_sram_ub_n  <= ~be_nxt[1];
               o_sram_dq_oe <= 1'b1;
            end
            default: begin
               o_sram_ce_n  <= 1'b1;
               o_sram_oe_n  <= 1'b1;
               o_sram_we_n  <= 1'b1;
               o_sram_lb_n  <= 1'b1;
               o_sram_ub_n  <= 1'b1;
               o_sram_dq_oe <= 1'b0;
            end
         endcase
         if (!i_wr_req || wr_sel)               rd_streak <= 8'd0;
         else if (rd_sel && rd_streak != 8'hFF) rd_streak <= rd_streak + 8'd1;
      end
   end

`ifdef SRAM_ARB_STATS_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_cnt_rd    <= 32'd0;
         o_cnt_wr    <= 32'd0;
         o_cnt_force <= 16'd0;
      end else begin
         if (rd_sel) o_cnt_rd <= o_cnt_rd + 32'd1;
         if (wr_sel) o_cnt_wr <= o_cnt_wr + 32'd1;
         if (arb && force_wr && o_cnt_force != 16'hFFFF) o_cnt_force <= o_cnt_force + 16'd1;
      end
   end
`else
   assign o_cnt_rd    = 32'd0;
   assign o_cnt_wr    = 32'd0;
   assign o_cnt_force = 16'd0;
`endif

endmodule
